// File: rtl/bcd_updown_counter_if.sv
// Control and count bus for the packed-BCD up/down counter.
// The master drives count/load requests; the slave (counter) returns count and flags.
interface bcd_updown_counter_if #(
  parameter int unsigned NUM_DIGITS = 2
);
  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic                    tc;
  logic                    load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  digits_out, tc, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output digits_out, tc, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with validated load, wrap/saturate bounds and
// a one-cycle terminal-count flag. All outputs registered; synchronous active-low reset.
module bcd_updown_counter #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  bcd_updown_counter_if.slave  bus_io
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         err_q, err_d;

  logic [W-1:0] stepped;
  logic [3:0]   dig;
  logic         carry;
  logic         all9, all0, load_ok, at_bound;

  // Digit-serial ripple; stepped is the wrapped result, so it doubles as the WRAP=1 bound value.
  always_comb begin
    stepped = '0;
    dig     = 4'd0;
    carry   = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    load_ok = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig = cnt_q[4*i +: 4];
      if (dig > 4'd9) dig = 4'd0;
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (bus_io.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (!carry) begin
        stepped[4*i +: 4] = dig;
      end else if (bus_io.up_dn) begin
        if (dig == 4'd9) begin
          stepped[4*i +: 4] = 4'd0;
        end else begin
          stepped[4*i +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        if (dig == 4'd0) begin
          stepped[4*i +: 4] = 4'd9;
        end else begin
          stepped[4*i +: 4] = dig - 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  assign at_bound = bus_io.up_dn ? all9 : all0;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (bus_io.load) begin
      if (load_ok) cnt_d = bus_io.load_val;
      else         err_d = 1'b1;
    end else if (bus_io.en) begin
      if (at_bound) begin
        tc_d = 1'b1;
        if (WRAP) cnt_d = stepped;
      end else begin
        cnt_d = stepped;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign bus_io.digits_out = cnt_q;
  assign bus_io.tc         = tc_q;
  assign bus_io.load_err   = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed vector table on a wrapping instance, a saturate
// sequence on a non-wrapping instance, then random stimulus on both against an integer model.
module tb_bcd_updown_counter;

  localparam int unsigned ND     = 2;
  localparam int          MaxVal = 99;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       en, up_dn, load;
  logic [7:0] load_val;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk1 = ~clk1;

  bcd_updown_counter_if #(.NUM_DIGITS(ND)) bus_u ();
  bcd_updown_counter_if #(.NUM_DIGITS(ND)) bus_s ();

  assign bus_u.en = en;  assign bus_u.up_dn = up_dn;
  assign bus_u.load = load;  assign bus_u.load_val = load_val;
  assign bus_s.en = en;  assign bus_s.up_dn = up_dn;
  assign bus_s.load = load;  assign bus_s.load_val = load_val;

  bcd_updown_counter #(.NUM_DIGITS(ND), .WRAP(1'b1)) dut_u (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .bus_io (bus_u.slave)
  );

  bcd_updown_counter #(.NUM_DIGITS(ND), .WRAP(1'b0)) dut_s (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .bus_io (bus_s.slave)
  );

  typedef struct packed {
    logic       rst_n;
    logic       load;
    logic       en;
    logic       up_dn;
    logic [7:0] load_val;
    logic [7:0] exp_d;
    logic       exp_tc;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic ld, input logic e, input logic u,
                     input logic [7:0] lv, input logic [7:0] d, input logic t, input logic er);
    vec_t v;
    v.rst_n = r; v.load = ld; v.en = e; v.up_dn = u; v.load_val = lv;
    v.exp_d = d; v.exp_tc = t; v.exp_err = er;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got digits=%h tc=%b err=%b, expected digits=%h tc=%b err=%b",
               name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                       input logic [7:0] lv);
    rst_n = r; load = ld; en = e; up_dn = u; load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int c);
    logic [7:0] r;
    r[7:4] = 4'(c / 10);
    r[3:0] = 4'(c % 10);
    return r;
  endfunction

  // Counter as a plain integer in 0..MaxVal.
  function automatic void model(input bit wrap, input int c, output int cn,
                                output bit tc, output bit err);
    cn = c; tc = 1'b0; err = 1'b0;
    if (!rst_n) cn = 0;
    else if (load) begin
      if (bcd_ok(load_val)) cn = bcd2int(load_val);
      else                  err = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (c == MaxVal) begin tc = 1'b1; cn = wrap ? 0 : MaxVal; end
        else cn = c + 1;
      end else begin
        if (c == 0) begin tc = 1'b1; cn = wrap ? MaxVal : 0; end
        else cn = c - 1;
      end
    end
  endfunction

  initial begin
    int         mu, ms, nu, ns;
    bit         tu, ts, eu, es;
    logic [7:0] lv;

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    //   rst ld en up  lval   digits tc err
    add(0, 1, 1, 1, 8'h42, 8'h00, 0, 0);
    add(0, 1, 1, 1, 8'h42, 8'h00, 0, 0);
    add(1, 1, 0, 1, 8'h08, 8'h08, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h09, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h10, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h11, 0, 0);
    add(1, 1, 0, 1, 8'h99, 8'h99, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h00, 1, 0);
    add(1, 0, 1, 1, 8'h00, 8'h01, 0, 0);
    add(1, 1, 0, 0, 8'h10, 8'h10, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h09, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h08, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h99, 1, 0);
    add(1, 0, 1, 0, 8'h00, 8'h98, 0, 0);
    add(1, 1, 0, 1, 8'h3A, 8'h98, 0, 1);
    add(1, 0, 0, 1, 8'h3A, 8'h98, 0, 0);
    add(1, 1, 1, 1, 8'h57, 8'h57, 0, 0);
    add(1, 1, 0, 1, 8'h50, 8'h50, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, i[0], 8'h00, 8'h50, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h51, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h50, 0, 0);
    add(1, 0, 1, 1, 8'h00, 8'h51, 0, 0);
    add(1, 0, 1, 0, 8'h00, 8'h50, 0, 0);
    add(1, 1, 1, 0, 8'hA0, 8'h50, 0, 1);
    add(1, 0, 1, 1, 8'h00, 8'h51, 0, 0);
    add(0, 1, 1, 1, 8'h77, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].load, tbl[i].en, tbl[i].up_dn, tbl[i].load_val);
      tick();
      check($sformatf("table[%0d]", i), {bus_u.digits_out, bus_u.tc, bus_u.load_err},
            {tbl[i].exp_d, tbl[i].exp_tc, tbl[i].exp_err});
    end

    // Saturating instance: holds at the bound and pulses tc on every enabled edge.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
    tick();
    check("sat_load99", {bus_s.digits_out, bus_s.tc, bus_s.load_err}, {8'h99, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
      tick();
      check($sformatf("sat_up[%0d]", i), {bus_s.digits_out, bus_s.tc, bus_s.load_err},
            {8'h99, 1'b1, 1'b0});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("sat_load00", {bus_s.digits_out, bus_s.tc, bus_s.load_err}, {8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      check($sformatf("sat_dn[%0d]", i), {bus_s.digits_out, bus_s.tc, bus_s.load_err},
            {8'h00, 1'b1, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    check("sat_leave0", {bus_s.digits_out, bus_s.tc, bus_s.load_err}, {8'h01, 1'b0, 1'b0});

    // Random phase; first edge is a reset so the model starts from a known state.
    mu = 0; ms = 0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        2:       lv = 8'($urandom);
        default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      drive((n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), lv);
      model(1'b1, mu, nu, tu, eu);
      model(1'b0, ms, ns, ts, es);
      mu = nu; ms = ns;
      tick();
      check($sformatf("rand_wrap[%0d]", n), {bus_u.digits_out, bus_u.tc, bus_u.load_err},
            {int2bcd(mu), tu, eu});
      check($sformatf("rand_sat[%0d]", n), {bus_s.digits_out, bus_s.tc, bus_s.load_err},
            {int2bcd(ms), ts, es});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
